// File: rtl/pattern_scan_arbiter_pkg.sv
// Shared definitions for the pattern scan arbiter.
// This file holds the scan FSM state encodings, the pattern, data and count
// widths, and the saturating match-count helper. The top module and the
// window sub-module both use it.
package pattern_scan_arbiter_pkg;

    localparam int PAT_W  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    // The match count stops at this value.
    localparam logic [CNT_W-1:0] MATCH_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_REPORT = 2'd3
    } scanState_t;

    // Adds one to the match count when inc is set, and never goes past MATCH_MAX.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != MATCH_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pattern_scan_arbiter_window_match.sv
// pattern_window_match: the 4-bit history window and its pattern comparator.
// Ports:
//   clock   - system clock
//   reset   - asynchronous, active-high reset
//   clear   - synchronous clear of the window and the fill count
//   shiftEn - shift bitIn into the window on this cycle
//   bitIn   - the next serial data bit (the window takes it at its LSB end)
//   pattern - the latched pattern to compare against
//   hit     - on a shift cycle, the window after this shift equals pattern
//   valid   - on a shift cycle, the window after this shift holds PAT_W real bits
// The compare works on the value the window will have after the shift. This
// lets the parent count a match on the same edge that shifts the bit in.
module pattern_window_match
    import pattern_scan_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shiftEn,
    input  logic             bitIn,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic             valid
);

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] windowNext;
    logic [2:0]       fill;

    assign windowNext = {window[PAT_W-2:0], bitIn};

    // Window and fill count. The fill count stops at PAT_W. After that point
    // every later window is a full and valid match candidate, so overlapping
    // matches are counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window <= '0;
            fill   <= '0;
        end else if (clear) begin
            window <= '0;
            fill   <= '0;
        end else if (shiftEn) begin
            window <= windowNext;
            if (fill != 3'(PAT_W)) begin
                fill <= fill + 3'd1;
            end
        end
    end

    assign hit   = shiftEn && (windowNext == pattern);
    assign valid = shiftEn && (fill >= 3'(PAT_W - 1));

endmodule

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: a two-requester, round-robin arbiter for a serial
// pattern scanner.
// Ports:
//   CLOCK      - system clock; all state changes on the rising edge
//   Rst        - asynchronous, active-high reset
//   req        - scan request level for each requester
//   data0/1    - byte to scan for requester 0 / 1
//   cfgPattern - 4-bit pattern; bit 3 is the first bit in time
//   grant      - one-hot, single-cycle acknowledge
//   busy       - high from the grant cycle through the done cycle
//   done       - single-cycle pulse when the result is valid
//   matchCount - number of overlapping matches in the byte (held until the next done)
//   resultId   - requester index of the result (held until the next done)
//   matchLed   - high for one tick period after a bit that completes a match
// The block shifts one bit MSB first on each divider tick. The winner is
// chosen on the edge that enters GRANT. The byte and the pattern are captured
// at the end of the grant cycle.
module pattern_scan_arbiter
    import pattern_scan_arbiter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              CLOCK,
    input  logic              Rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [PAT_W-1:0]  cfgPattern,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  matchCount,
    output logic              resultId,
    output logic              matchLed
);

    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    scanState_t        state;
    scanState_t        nextState;
    logic [DIV_W-1:0]  divCnt;
    logic              tick;
    logic              winnerId;
    logic              grantId;
    logic              rrLast;
    logic [DATA_W-1:0] dataSh;
    logic [PAT_W-1:0]  patLatch;
    logic              idLatch;
    logic [2:0]        bitCnt;
    logic [CNT_W-1:0]  matchCnt;
    logic              shiftEn;
    logic              winHit;
    logic              winValid;
    logic              countHit;
    logic              lastBit;

    // Free-running bit-rate divider. It gives a one-cycle tick every DIV
    // cycles. It runs all the time, so the first shift of a scan can come at
    // any point from 1 to DIV cycles after the grant cycle.
    always_ff @(posedge CLOCK or posedge Rst) begin
        if (Rst) begin
            divCnt <= '0;
        end else if (divCnt == DIV_LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = (divCnt == DIV_LAST);

    // Round-robin choice. A single requester always wins. When both request,
    // the requester that was not served last wins. rrLast resets to 1, so
    // requester 0 has priority after reset.
    always_comb begin
        winnerId = 1'b0;
        case (req)
            2'b01:   winnerId = 1'b0;
            2'b10:   winnerId = 1'b1;
            2'b11:   winnerId = ~rrLast;
            default: winnerId = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    assign lastBit = (bitCnt == 3'd7);

    // FSM next-state logic.
    always_comb begin
        nextState = ST_IDLE;
        case (state)
            ST_IDLE:   nextState = (req != 2'b00) ? ST_GRANT : ST_IDLE;
            ST_GRANT:  nextState = ST_SHIFT;
            ST_SHIFT:  nextState = (tick && lastBit) ? ST_REPORT : ST_SHIFT;
            ST_REPORT: nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // FSM outputs. grant comes only from registered state, so it does not
    // change if a requester drops req while its grant is shown.
    always_comb begin
        grant = 2'b00;
        busy  = (state != ST_IDLE);
        done  = (state == ST_REPORT);
        if (state == ST_GRANT) begin
            grant = grantId ? 2'b10 : 2'b01;
        end
    end

    assign shiftEn  = (state == ST_SHIFT) && tick;
    assign countHit = winHit && winValid;

    // Scan datapath. The winner id is captured on entry to GRANT. The byte
    // and the pattern are captured as GRANT ends. During SHIFT, each tick
    // moves one bit out. The final count and id go to the held outputs on
    // the 8th tick, so they are already valid in the done cycle.
    always_ff @(posedge CLOCK or posedge Rst) begin
        if (Rst) begin
            grantId    <= 1'b0;
            rrLast     <= 1'b1;
            dataSh     <= '0;
            patLatch   <= '0;
            idLatch    <= 1'b0;
            bitCnt     <= '0;
            matchCnt   <= '0;
            matchCount <= '0;
            resultId   <= 1'b0;
            matchLed   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grantId <= winnerId;
                    end
                end
                ST_GRANT: begin
                    dataSh   <= grantId ? data1 : data0;
                    patLatch <= cfgPattern;
                    idLatch  <= grantId;
                    bitCnt   <= '0;
                    matchCnt <= '0;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        dataSh   <= {dataSh[DATA_W-2:0], 1'b0};
                        bitCnt   <= bitCnt + 1'b1;
                        matchCnt <= satInc(matchCnt, countHit);
                        matchLed <= countHit;
                        if (lastBit) begin
                            matchCount <= satInc(matchCnt, countHit);
                            resultId   <= idLatch;
                        end
                    end
                end
                ST_REPORT: begin
                    rrLast   <= idLatch;
                    matchLed <= 1'b0;
                end
                default: begin
                    matchLed <= 1'b0;
                end
            endcase
        end
    end

    pattern_window_match uWindow (
        .clock   (CLOCK),
        .reset   (Rst),
        .clear   (state == ST_GRANT),
        .shiftEn (shiftEn),
        .bitIn   (dataSh[DATA_W-1]),
        .pattern (patLatch),
        .hit     (winHit),
        .valid   (winValid)
    );

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Testbench for pattern_scan_arbiter.
// Each test pushes the expected grant and scan result into queues when it
// drives its inputs. A separate monitor checks each grant and done pulse
// against the front of those queues.
module tb_pattern_scan_arbiter;
    import pattern_scan_arbiter_pkg::*;

    localparam int DIV           = 4;
    localparam int LAT_MIN       = 7 * DIV + 2;
    localparam int LAT_MAX       = 8 * DIV + 2;
    localparam int LAT_ALIGN_MIN = 8 * DIV + 1;
    localparam int WAIT_BOUND    = 20 * DIV + 100;

    typedef struct {
        int id;
        int cnt;
        int pulses;
        int high;
        int latMin;
        int latMax;
    } scanExp_t;

    logic              CLOCK;
    logic              Rst;
    logic [1:0]        req;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [PAT_W-1:0]  cfgPattern;
    logic [1:0]        grant;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  matchCount;
    logic              resultId;
    logic              matchLed;

    scanExp_t   expQ[$];
    logic [1:0] grantQ[$];
    int total = 0;
    int bad   = 0;
    int divModel;

    pattern_scan_arbiter #(.DIV(DIV)) dut (
        .CLOCK      (CLOCK),
        .Rst        (Rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .cfgPattern (cfgPattern),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .matchCount (matchCount),
        .resultId   (resultId),
        .matchLed   (matchLed)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Model of the free-running divider phase. Tests use it to start a
    // request so that the grant cycle falls on a tick.
    always @(posedge CLOCK or posedge Rst) begin
        if (Rst) divModel <= 0;
        else     divModel <= (divModel == DIV - 1) ? 0 : divModel + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual < lo || actual > hi) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"},      int'(grant),      0);
        checkOutput({tag, "_busy"},       int'(busy),       0);
        checkOutput({tag, "_done"},       int'(done),       0);
        checkOutput({tag, "_matchCount"}, int'(matchCount), 0);
        checkOutput({tag, "_resultId"},   int'(resultId),   0);
        checkOutput({tag, "_matchLed"},   int'(matchLed),   0);
    endtask

    task automatic pushScan(input int id, input int cnt, input int pulses,
                            input int high, input int latMin, input int latMax);
        scanExp_t s;
        s.id = id; s.cnt = cnt; s.pulses = pulses;
        s.high = high; s.latMin = latMin; s.latMax = latMax;
        expQ.push_back(s);
        grantQ.push_back(id != 0 ? 2'b10 : 2'b01);
    endtask

    // Waits until the block is idle. When align is set, it also waits until
    // the divider phase puts the grant cycle on a tick. Then it drives the
    // request inputs.
    task automatic applyStimulus(input logic [1:0] reqV, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [3:0] pat,
                                 input bit align);
        @(negedge CLOCK);
        for (int i = 0; i < WAIT_BOUND && busy; i++) @(negedge CLOCK);
        if (busy) checkOutput("idleTimeout", 1, 0);
        if (align) begin
            for (int i = 0; i < 2 * DIV && divModel != DIV - 2; i++) @(negedge CLOCK);
        end
        req        = reqV;
        data0      = d0;
        data1      = d1;
        cfgPattern = pat;
    endtask

    // Waits for the grant bit of a requester, then drops that request after
    // the grant cycle ends.
    task automatic waitGrantDrop(input int idx);
        bit seen = 0;
        for (int i = 0; i < WAIT_BOUND && !seen; i++) begin
            @(negedge CLOCK);
            if (grant[idx]) seen = 1;
        end
        if (!seen) checkOutput("grantTimeout", 0, 1);
        @(posedge CLOCK);
        #1;
        req[idx] = 1'b0;
    endtask

    task automatic waitDone();
        @(negedge CLOCK);
        for (int i = 0; i < WAIT_BOUND && busy; i++) @(negedge CLOCK);
        if (busy) checkOutput("doneTimeout", 1, 0);
    endtask

    // Monitor: checks each grant and done pulse against the queues. It also
    // measures grant-to-done latency and the matchLed activity of each scan.
    initial begin : monitor
        logic     prevBusy;
        logic     prevLed;
        int       cyc;
        int       grantCyc;
        int       ledPulses;
        int       ledHigh;
        scanExp_t e;
        logic [1:0] g;
        prevBusy = 0; prevLed = 0; cyc = 0; grantCyc = 0; ledPulses = 0; ledHigh = 0;
        forever begin
            @(negedge CLOCK);
            if (Rst) begin
                prevBusy = 0;
                prevLed  = 0;
            end else begin
                cyc++;
                if (grant != 2'b00) begin
                    checkOutput("grantWhileBusy", int'(prevBusy), 0);
                    if (grantQ.size() == 0) begin
                        checkOutput("unexpectedGrant", int'(grant), 0);
                    end else begin
                        g = grantQ.pop_front();
                        checkOutput("grant", int'(grant), int'(g));
                    end
                    grantCyc  = cyc;
                    ledPulses = 0;
                    ledHigh   = 0;
                end
                if (matchLed) ledHigh++;
                if (matchLed && !prevLed) ledPulses++;
                if (done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedDone", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("matchCount", int'(matchCount), e.cnt);
                        checkOutput("resultId", int'(resultId), e.id);
                        checkOutput("ledPulses", ledPulses, e.pulses);
                        checkOutput("ledHighCycles", ledHigh, e.high);
                        checkRange("latency", cyc - grantCyc, e.latMin, e.latMax);
                    end
                end
                prevBusy = busy;
                prevLed  = matchLed;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        Rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; cfgPattern = '0;
        repeat (3) @(negedge CLOCK);
        checkResetOutputs("por");
        Rst = 1'b0;

        // Single requester 0: two matches of 1101 in 11011010, after bits 4 and 7.
        pushScan(0, 2, 2, 2 * DIV, LAT_MIN, LAT_MAX);
        applyStimulus(2'b01, 8'b11011010, 8'h00, 4'b1101, 0);
        waitGrantDrop(0);
        waitDone();

        // Requester 1, all ones: five overlapping matches. matchLed stays high from bit 4 through the done cycle.
        pushScan(1, 5, 1, 4 * DIV + 1, LAT_MIN, LAT_MAX);
        applyStimulus(2'b10, 8'h00, 8'hFF, 4'b1111, 0);
        waitGrantDrop(1);
        waitDone();

        // Reset clears the held result of 5.
        @(negedge CLOCK);
        Rst = 1'b1;
        @(negedge CLOCK);
        checkResetOutputs("rst2");
        Rst = 1'b0;

        // Both request after reset: requester 0 first, then requester 1.
        pushScan(0, 3, 3, 2 * DIV + 1, LAT_MIN, LAT_MAX);
        pushScan(1, 1, 1, DIV, LAT_MIN, LAT_MAX);
        applyStimulus(2'b11, 8'b10101010, 8'b01010000, 4'b1010, 0);
        waitGrantDrop(0);
        waitGrantDrop(1);
        waitDone();

        // Zero data with the grant on a tick: no matches, latency is the maximum.
        pushScan(0, 0, 0, 0, LAT_ALIGN_MIN, LAT_MAX);
        applyStimulus(2'b01, 8'h00, 8'h00, 4'b1101, 1);
        waitGrantDrop(0);
        waitDone();

        // Pattern changed mid-scan: the result uses the pattern 0110 captured at grant.
        pushScan(0, 2, 2, 2 * DIV, LAT_MIN, LAT_MAX);
        applyStimulus(2'b01, 8'b01101100, 8'h00, 4'b0110, 0);
        waitGrantDrop(0);
        repeat (3 * DIV) @(negedge CLOCK);
        cfgPattern = 4'b1111;
        waitDone();

        // Abort during bit 5. The previous result is held until then.
        grantQ.push_back(2'b01);
        applyStimulus(2'b01, 8'hFF, 8'h00, 4'b1111, 1);
        waitGrantDrop(0);
        checkOutput("holdCount", int'(matchCount), 2);
        checkOutput("holdId", int'(resultId), 0);
        repeat (4 * DIV + DIV / 2 - 1) @(negedge CLOCK);
        checkOutput("ledBeforeAbort", int'(matchLed), 1);
        Rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        @(negedge CLOCK);
        req = 2'b00;
        Rst = 1'b0;

        // After the abort, a tie goes to requester 0 again.
        pushScan(0, 1, 1, DIV, LAT_MIN, LAT_MAX);
        pushScan(1, 2, 1, DIV + 1, LAT_MIN, LAT_MAX);
        applyStimulus(2'b11, 8'hF0, 8'h1F, 4'b1111, 0);
        waitGrantDrop(0);
        waitGrantDrop(1);
        waitDone();

        repeat (5) @(negedge CLOCK);
        checkOutput("scanQueueLeft", expQ.size(), 0);
        checkOutput("grantQueueLeft", grantQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
